// File: rtl/int_sequencer.sv
// int_sequencer: interrupt / reset vector sequencer for the 6502 core.
// Watches RESET, NMI (falling edge), IRQ (level, masked by iflag) and BRK.
// At an instruction boundary it picks the highest-priority request and runs
// the push / vector-fetch sequence. Reset skips the three pushes.
//
// Optional build macro: BRK_HIJACK_EN. When it is defined, an NMI that is
// pending in PUSHP takes over a BRK/IRQ sequence and the core fetches the
// NMI vector instead.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   res_n              reset request pin (active low, sampled)
//   nmi_n              NMI pin (active low, falling-edge sensitive)
//   irq_n              IRQ pin (active low, level sensitive)
//   iflag              I flag from P (1 = IRQ masked)
//   sync               opcode fetch cycle (instruction boundary)
//   brk                BRK opcode decoded, valid with sync
//   busy               a sequence is in progress
//   pushsel            stack data select: 00 none, 01 PCH, 10 PCL, 11 P
//   stackwe            stack write strobe
//   bpush              B bit for the pushed P (set only for BRK)
//   setreset/irq/nmi   one-cycle pulses that force PCH to 8'hff
//   vecadl, adloa      vector low address byte and its bus enable
//   setiflag           one-cycle pulse to set the I flag
//   done               one-cycle pulse on the last sequence cycle
module int_sequencer #(
  parameter logic [7:0] NMIVEC = 8'hfa,
  parameter logic [7:0] RESVEC = 8'hfc,
  parameter logic [7:0] IRQVEC = 8'hfe
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       res_n,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       iflag,
  input  logic       sync,
  input  logic       brk,
  output logic       busy,
  output logic [1:0] pushsel,
  output logic       stackwe,
  output logic       bpush,
  output logic       setreset,
  output logic       setirq,
  output logic       setnmi,
  output logic [7:0] vecadl,
  output logic       adloa,
  output logic       setiflag,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, PUSHH, PUSHL, PUSHP, FETCHLO, FETCHHI
  } state_t;

  typedef enum logic [1:0] {
    SRC_IRQ = 2'b00,
    SRC_BRK = 2'b01,
    SRC_NMI = 2'b10,
    SRC_RES = 2'b11
  } src_t;

  state_t state;
  src_t   src;
  logic   rstpend;
  logic   nmipend;
  logic   nmi_q;
  logic [7:0] vec;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      src     <= SRC_RES;
      rstpend <= 1'b1;
      nmipend <= 1'b0;
      nmi_q   <= 1'b1;
    end else begin
      nmi_q <= nmi_n;

      // A new edge takes priority over the clear in the same cycle.
      if (nmi_q && !nmi_n)
        nmipend <= 1'b1;
      else if (state == FETCHLO && src == SRC_NMI)
        nmipend <= 1'b0;

      if (!res_n) begin
        rstpend <= 1'b1;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rstpend) begin
              // Reset does not wait for an instruction boundary.
              rstpend <= 1'b0;
              src     <= SRC_RES;
              state   <= FETCHLO;
            end else if (sync) begin
              if (nmipend) begin
                src   <= SRC_NMI;
                state <= PUSHH;
              end else if (brk) begin
                src   <= SRC_BRK;
                state <= PUSHH;
              end else if (!irq_n && !iflag) begin
                src   <= SRC_IRQ;
                state <= PUSHH;
              end
            end
          end
          PUSHH:   state <= PUSHL;
          PUSHL:   state <= PUSHP;
          PUSHP: begin
            state <= FETCHLO;
`ifdef BRK_HIJACK_EN
            // P has already been pushed with the BRK bit, only the vector changes.
            if (nmipend && (src == SRC_BRK || src == SRC_IRQ))
              src <= SRC_NMI;
`endif
          end
          FETCHLO: state <= FETCHHI;
          FETCHHI: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (src)
      SRC_RES: vec = RESVEC;
      SRC_NMI: vec = NMIVEC;
      default: vec = IRQVEC;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    pushsel  = 2'b00;
    stackwe  = 1'b0;
    bpush    = 1'b0;
    setreset = 1'b0;
    setirq   = 1'b0;
    setnmi   = 1'b0;
    vecadl   = '0;
    adloa    = 1'b0;
    setiflag = 1'b0;
    done     = 1'b0;
    case (state)
      PUSHH: begin
        pushsel = 2'b01;
        stackwe = 1'b1;
      end
      PUSHL: begin
        pushsel = 2'b10;
        stackwe = 1'b1;
      end
      PUSHP: begin
        pushsel = 2'b11;
        stackwe = 1'b1;
        bpush   = (src == SRC_BRK);
      end
      FETCHLO: begin
        adloa    = 1'b1;
        vecadl   = vec;
        setreset = (src == SRC_RES);
        setnmi   = (src == SRC_NMI);
        setirq   = (src == SRC_IRQ) || (src == SRC_BRK);
      end
      FETCHHI: begin
        adloa    = 1'b1;
        vecadl   = vec | 8'h01;
        setiflag = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Testbench for int_sequencer: a table of per-cycle input vectors with the
// outputs expected after the following clock edge. The expected outputs go
// through a scoreboard queue and are compared one cycle later. A hand-written
// sequence then checks the IRQ latency using a bounded wait.
module tb_int_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       res_n, nmi_n, irq_n, iflag, sync, brk;
  logic       busy, stackwe, bpush, setreset, setirq, setnmi, adloa, setiflag, done;
  logic [1:0] pushsel;
  logic [7:0] vecadl;

  int_sequencer #(.NMIVEC(8'hfa), .RESVEC(8'hfc), .IRQVEC(8'hfe)) dut (
    .clk(clk), .rstn(rstn), .res_n(res_n), .nmi_n(nmi_n), .irq_n(irq_n),
    .iflag(iflag), .sync(sync), .brk(brk), .busy(busy), .pushsel(pushsel),
    .stackwe(stackwe), .bpush(bpush), .setreset(setreset), .setirq(setirq),
    .setnmi(setnmi), .vecadl(vecadl), .adloa(adloa), .setiflag(setiflag),
    .done(done)
  );

  always #5 clk = ~clk;

  // {busy, pushsel, stackwe, bpush, setreset, setirq, setnmi, vecadl, adloa, setiflag, done}
  logic [18:0] got;
  assign got = {busy, pushsel, stackwe, bpush, setreset, setirq, setnmi,
                vecadl, adloa, setiflag, done};

  typedef struct {
    string       name;
    logic [5:0]  in;   // {res_n, nmi_n, irq_n, iflag, sync, brk}
    logic [18:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [18:0] exp_q[$];
  int          lat_q[$];
  int          tests = 0;
  int          fails = 0;

  localparam int P_IDLE = 0, P_PH = 1, P_PL = 2, P_PP = 3, P_VLO = 4, P_VHI = 5;

  // Expected outputs for one phase of a sequence. For FETCHLO the pulse
  // follows from the vector: fc reset, fa NMI, fe IRQ/BRK.
  function automatic logic [18:0] eo(int ph, logic [7:0] v, logic b);
    logic       bsy, swe, bp, sr, si, sn, ad, sif, dn;
    logic [1:0] ps;
    logic [7:0] va;
    bsy = (ph != P_IDLE);
    ps = 2'b00; swe = 0; bp = 0; sr = 0; si = 0; sn = 0;
    va = 8'h00; ad = 0; sif = 0; dn = 0;
    case (ph)
      P_PH:  begin ps = 2'b01; swe = 1; end
      P_PL:  begin ps = 2'b10; swe = 1; end
      P_PP:  begin ps = 2'b11; swe = 1; bp = b; end
      P_VLO: begin
        va = v; ad = 1;
        sr = (v == 8'hfc); sn = (v == 8'hfa); si = (v == 8'hfe);
      end
      P_VHI: begin va = v; ad = 1; sif = 1; dn = 1; end
      default: ;
    endcase
    return {bsy, ps, swe, bp, sr, si, sn, va, ad, sif, dn};
  endfunction

  function automatic void add(string n, logic [5:0] i, logic [18:0] e);
    vec_t v;
    v.name = n; v.in = i; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic chk(string n, logic [18:0] a, logic [18:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %05h expected %05h", n, a, e);
    end
  endtask

  task automatic drive(logic [5:0] i);
    {res_n, nmi_n, irq_n, iflag, sync, brk} = i;
  endtask

  localparam logic [5:0] IDL = 6'b111100;

  initial begin
    logic [18:0] e;
    int cnt;
    int el;

    // reset sequence
    add("res_lo",   IDL,       eo(P_VLO, 8'hfc, 0));
    add("res_hi",   IDL,       eo(P_VHI, 8'hfd, 0));
    add("res_end",  IDL,       eo(P_IDLE, 8'h00, 0));
    // NMI edge with no sync, serviced two cycles later
    add("nmi_fall", 6'b101100, eo(P_IDLE, 8'h00, 0));
    add("nmi_wait", 6'b101100, eo(P_IDLE, 8'h00, 0));
    add("nmi_sync", 6'b101110, eo(P_PH, 8'h00, 0));
    add("nmi_pl",   IDL,       eo(P_PL, 8'h00, 0));
    add("nmi_pp",   IDL,       eo(P_PP, 8'h00, 0));
    add("nmi_vlo",  IDL,       eo(P_VLO, 8'hfa, 0));
    add("nmi_vhi",  IDL,       eo(P_VHI, 8'hfb, 0));
    add("nmi_end",  IDL,       eo(P_IDLE, 8'h00, 0));
    add("nmi_clr",  6'b111110, eo(P_IDLE, 8'h00, 0));
    // IRQ masked, then unmasked
    add("irq_mask", 6'b110110, eo(P_IDLE, 8'h00, 0));
    add("irq_go",   6'b110010, eo(P_PH, 8'h00, 0));
    add("irq_pl",   IDL,       eo(P_PL, 8'h00, 0));
    add("irq_pp",   IDL,       eo(P_PP, 8'h00, 0));
    add("irq_vlo",  IDL,       eo(P_VLO, 8'hfe, 0));
    add("irq_vhi",  IDL,       eo(P_VHI, 8'hff, 0));
    add("irq_end",  IDL,       eo(P_IDLE, 8'h00, 0));
    // IRQ not latched
    add("irq_nosy", 6'b110000, eo(P_IDLE, 8'h00, 0));
    add("irq_gone", 6'b111010, eo(P_IDLE, 8'h00, 0));
    // BRK beats IRQ
    add("brk_go",   6'b110011, eo(P_PH, 8'h00, 0));
    add("brk_pl",   IDL,       eo(P_PL, 8'h00, 0));
    add("brk_pp",   IDL,       eo(P_PP, 8'h00, 1));
    add("brk_vlo",  IDL,       eo(P_VLO, 8'hfe, 0));
    add("brk_vhi",  IDL,       eo(P_VHI, 8'hff, 0));
    add("brk_end",  IDL,       eo(P_IDLE, 8'h00, 0));
    // pending NMI beats BRK
    add("bn_fall",  6'b101100, eo(P_IDLE, 8'h00, 0));
    add("bn_go",    6'b100011, eo(P_PH, 8'h00, 0));
    add("bn_pl",    6'b101100, eo(P_PL, 8'h00, 0));
    add("bn_pp",    6'b101100, eo(P_PP, 8'h00, 0));
    add("bn_vlo",   6'b101100, eo(P_VLO, 8'hfa, 0));
    add("bn_vhi",   IDL,       eo(P_VHI, 8'hfb, 0));
    add("bn_end",   IDL,       eo(P_IDLE, 8'h00, 0));
    // reset request aborts an IRQ sequence in PUSHL
    add("abt_go",   6'b110010, eo(P_PH, 8'h00, 0));
    add("abt_pl",   IDL,       eo(P_PL, 8'h00, 0));
    add("abt_res",  6'b011100, eo(P_IDLE, 8'h00, 0));
    add("abt_hold", 6'b011100, eo(P_IDLE, 8'h00, 0));
    add("abt_rlo",  IDL,       eo(P_VLO, 8'hfc, 0));
    add("abt_rhi",  IDL,       eo(P_VHI, 8'hfd, 0));
    add("abt_end",  IDL,       eo(P_IDLE, 8'h00, 0));
    // NMI edge during a BRK sequence (PUSHL)
    add("hj_go",    6'b111111, eo(P_PH, 8'h00, 0));
    add("hj_pl",    IDL,       eo(P_PL, 8'h00, 0));
    add("hj_nmi",   6'b101100, eo(P_PP, 8'h00, 1));
`ifdef BRK_HIJACK_EN
    add("hj_vlo",   6'b101100, eo(P_VLO, 8'hfa, 0));
    add("hj_vhi",   6'b101100, eo(P_VHI, 8'hfb, 0));
    add("hj_end",   6'b101100, eo(P_IDLE, 8'h00, 0));
    add("hj_clr",   6'b101110, eo(P_IDLE, 8'h00, 0));
`else
    add("hj_vlo",   6'b101100, eo(P_VLO, 8'hfe, 0));
    add("hj_vhi",   6'b101100, eo(P_VHI, 8'hff, 0));
    add("hj_end",   6'b101100, eo(P_IDLE, 8'h00, 0));
    add("hj_n_go",  6'b101110, eo(P_PH, 8'h00, 0));
    add("hj_n_pl",  6'b101100, eo(P_PL, 8'h00, 0));
    add("hj_n_pp",  6'b101100, eo(P_PP, 8'h00, 0));
    add("hj_n_vlo", 6'b101100, eo(P_VLO, 8'hfa, 0));
    add("hj_n_vhi", IDL,       eo(P_VHI, 8'hfb, 0));
    add("hj_n_end", IDL,       eo(P_IDLE, 8'h00, 0));
`endif

    rstn = 1'b0;
    drive(IDL);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", got, '0);
    rstn = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].in);
      exp_q.push_back(tbl[k].exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk(tbl[k].name, got, e);
    end

    // IRQ latency: done must appear on the fifth cycle after the sync cycle.
    drive(IDL);
    @(posedge clk); #1;
    drive(6'b110010);
    lat_q.push_back(5);
    cnt = 0;
    while (cnt < 10) begin
      @(posedge clk); #1;
      drive(IDL);
      cnt++;
      if (done) break;
    end
    el = lat_q.pop_front();
    tests++;
    if (cnt != el) begin
      fails++;
      $display("FAIL irq_latency: got %0d cycles expected %0d", cnt, el);
    end
    @(posedge clk); #1;
    chk("irq_after", got, eo(P_IDLE, 8'h00, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
